imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_if.sv | 26 ++
 rtl/imm_extend_pipe.sv | 97 +++++++++
 tb/tb_imm_extend_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: input immediate/mode stream and
// extended-immediate output stream with error status.
interface imm_extend_pipe_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [25:0]       Imm26;
    logic [2:0]        Ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] BusImm;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output in_valid, Imm26, Ctrl, out_ready,
        input  in_ready, out_valid, BusImm, out_err, err_count
    );

    modport slave (
        input  in_valid, Imm26, Ctrl, out_ready,
        output in_ready, out_valid, BusImm, out_err, err_count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender (I/D/B/CB, optional MOVZ) with valid/ready flow.
// Define IMM_EXTEND_MOVZ_EN to enable Ctrl=100 (MOVZ); otherwise it is illegal.
module imm_extend_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input logic          CLK,
    input logic          Reset,
    imm_extend_pipe_if.slave bus
);
    logic              s1_valid;
    logic [25:0]       s1_imm;
    logic [2:0]        s1_ctrl;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_imm;
    logic              s2_err;
    logic [CNT_W-1:0]  err_cnt;

    logic              s2_free;
    logic              s1_adv;
    logic              in_fire;
    logic              out_fire;
    logic [63:0]       ext;
    logic              ext_err;

    assign s2_free  = !s2_valid || bus.out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready  = !Reset && (!s1_valid || s1_adv);
    assign bus.out_valid = s2_valid;
    assign bus.BusImm    = s2_imm;
    assign bus.out_err   = s2_err;
    assign bus.err_count = err_cnt;

    // Extension is computed at full 64 bits; a 32-bit build keeps the low half.
    always_comb begin
        ext     = '0;
        ext_err = 1'b0;
        unique case (s1_ctrl)
            3'b000: ext = {52'd0, s1_imm[21:10]};
            3'b001: ext = {{55{s1_imm[20]}}, s1_imm[20:12]};
            3'b010: ext = {{36{s1_imm[25]}}, s1_imm, 2'b00};
            3'b011: ext = {{43{s1_imm[23]}}, s1_imm[23:5], 2'b00};
            3'b100: begin
`ifdef IMM_EXTEND_MOVZ_EN
                if (DATA_W == 32 && s1_imm[22]) begin
                    ext_err = 1'b1;
                end else begin
                    ext = {48'd0, s1_imm[20:5]} << {s1_imm[22:21], 4'd0};
                end
`else
                ext_err = 1'b1;
`endif
            end
            default: ext_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_ctrl  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_imm   <= bus.Imm26;
            s1_ctrl  <= bus.Ctrl;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output registers only move when empty or delivering, so a stall holds them.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            s2_valid <= 1'b0;
            s2_imm   <= '0;
            s2_err   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_imm <= ext[DATA_W-1:0];
                s2_err <= ext_err;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            err_cnt <= '0;
        end else if (out_fire && s2_err && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus random traffic
// against a queue-based arithmetic reference model.
module tb_imm_extend_pipe;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 8;
    localparam logic [63:0] MASK = {64{1'b1}} >> (64 - DATA_W);
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imm_extend_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    imm_extend_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cnt = 0;
    bit   post_rst = 1'b0;
    exp_t q[$];

    logic              s_rdy;
    logic              s_vld;
    logic [63:0]       s_bus;
    logic              s_err;
    logic [CNT_W-1:0]  s_cnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_model(logic [2:0] c, logic [25:0] i);
        exp_t   r;
        longint v;
        longint ii;
        ii = longint'(i);
        v = 0;
        r.e = 1'b0;
        r.t = 0;
        case (c)
            3'd0: v = (ii >> 10) & 64'hFFF;
            3'd1: begin
                v = (ii >> 12) & 64'h1FF;
                if (v > 255) v -= 512;
            end
            3'd2: begin
                v = ii;
                if (v >= 64'h200_0000) v -= 64'h400_0000;
                v = v * 4;
            end
            3'd3: begin
                v = (ii >> 5) & 64'h7FFFF;
                if (v >= 64'h40000) v -= 64'h80000;
                v = v * 4;
            end
`ifdef IMM_EXTEND_MOVZ_EN
            3'd4: begin
                if (DATA_W == 32 && ((ii >> 21) & 3) >= 2) r.e = 1'b1;
                else v = ((ii >> 5) & 64'hFFFF) << (16 * ((ii >> 21) & 3));
            end
`endif
            default: r.e = 1'b1;
        endcase
        r.d = 64'(v) & MASK;
        return r;
    endfunction

    task automatic step();
        bit   exp_rdy;
        bit   exp_vld;
        bit   in_fire;
        bit   out_fire;
        exp_t n;
        @(negedge clk);
        exp_rdy = !rst && (q.size() < 2 || bus.out_ready);
        exp_vld = q.size() > 0 && cyc >= q[0].t + 2;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        chk("err_count", 64'(bus.err_count), 64'(cnt));
        if (exp_vld) begin
            chk("bus_imm", 64'(bus.BusImm), q[0].d);
            chk("out_err", 64'(bus.out_err), 64'(q[0].e));
        end
        if (post_rst) begin
            chk("rst_bus", 64'(bus.BusImm), 64'd0);
            chk("rst_err", 64'(bus.out_err), 64'd0);
        end
        s_rdy = bus.in_ready;
        s_vld = bus.out_valid;
        s_bus = 64'(bus.BusImm);
        s_err = bus.out_err;
        s_cnt = bus.err_count;
        in_fire  = bus.in_valid && exp_rdy;
        out_fire = exp_vld && bus.out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt = 0;
            post_rst = 1'b1;
        end else begin
            post_rst = 1'b0;
            if (out_fire) begin
                if (q[0].e && cnt < CMAX) cnt++;
                void'(q.pop_front());
            end
            if (in_fire) begin
                n = ref_model(bus.Ctrl, bus.Imm26);
                n.t = cyc;
                q.push_back(n);
            end
        end
        cyc++;
        #1;
    endtask

    // Single transfer with out_ready high; result must show exactly 2 cycles later.
    task automatic one(string tag, logic [2:0] c, logic [25:0] i,
                       logic [63:0] d, logic e);
        bus.in_valid = 1'b1;
        bus.Ctrl     = c;
        bus.Imm26    = i;
        step();
        chk({tag, "_acc"}, 64'(s_rdy), 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_lat1"}, 64'(s_vld), 64'd0);
        step();
        chk({tag, "_lat2"}, 64'(s_vld), 64'd1);
        chk({tag, "_val"}, s_bus, d & MASK);
        chk({tag, "_err"}, 64'(s_err), 64'(e));
    endtask

    initial begin
        logic [25:0]  imm;
        int           k;
        int           acc;
        logic [63:0]  got[$];

        bus.in_valid  = 1'b0;
        bus.Imm26     = '0;
        bus.Ctrl      = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        imm = 26'($urandom);
        imm[20:12] = 9'h1FF;
        one("d_max", 3'b001, imm, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        one("b_max", 3'b010, 26'h3FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        one("cb_one", 3'b011, 26'h000_0020, 64'h4, 1'b0);
`ifdef IMM_EXTEND_MOVZ_EN
        one("movz", 3'b100, 26'h057_DDE0, 64'h0000_BEEF_0000_0000, 1'b0);
`else
        one("movz", 3'b100, 26'h057_DDE0, 64'h0, 1'b1);
`endif

        // Back-pressure: only two entries fit, then drain in order.
        bus.out_ready = 1'b0;
        bus.Ctrl      = 3'b000;
        k = 1;
        bus.Imm26     = 26'(k << 10);
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (bus.in_valid && s_rdy && k < 3) begin
                k++;
                bus.Imm26 = 26'(k << 10);
            end
        end
        chk("stall_rdy", 64'(s_rdy), 64'd0);
        chk("stall_acc", 64'(k), 64'd3);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (s_vld) got.push_back(s_bus);
            if (bus.in_valid && s_rdy) begin
                if (k < 3) begin
                    k++;
                    bus.Imm26 = 26'(k << 10);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        chk("drain_n", 64'(got.size()), 64'd3);
        for (int n = 0; n < 3 && n < got.size(); n++) begin
            chk("drain_ord", got[n], 64'(n + 1));
        end

        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.Ctrl      = 3'($urandom_range(0, 7));
            bus.Imm26     = 26'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        acc = 0;
        bus.Ctrl     = 3'b111;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 400 && acc < 300; n++) begin
            bus.Imm26 = 26'($urandom);
            step();
            if (s_rdy) acc++;
            if (acc >= 300) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("ill_acc", 64'(acc), 64'd300);
        chk("ill_sat", 64'(s_cnt), 64'(CMAX));

        bus.out_ready = 1'b0;
        bus.Ctrl      = 3'b000;
        bus.in_valid  = 1'b1;
        bus.Imm26     = 26'h3FF_FFFF;
        repeat (2) step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_vld", 64'(s_vld), 64'd0);
        chk("rst_cnt", 64'(s_cnt), 64'd0);
        bus.out_ready = 1'b1;
        one("post_rst", 3'b000, 26'h000_1400, 64'h5, 1'b0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
